// File: rtl/division_restauracion_pkg.sv
`default_nettype none
// ============================================================================
// Package : division_pkg
// Purpose : Shared definitions for the restoring divider.
//           - estado_t  : controller states
//           - N_DEF     : default operand width
//           - cnt_width : width of the iteration counter for a given N
// Revision: 1.0 - initial release
// ============================================================================
package division_pkg;

    localparam int N_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPERA  = 2'd1,
        AJUSTE = 2'd2,
        HECHO  = 2'd3
    } estado_t;

    // The counter is loaded with N, so it must hold values up to N.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/division_restauracion_sum_resta_n.sv
`default_nettype none
// ============================================================================
// Module  : sum_resta_n
// Purpose : W-bit adder/subtractor. resta_i=0 gives a+b, resta_i=1 gives a-b
//           (two's complement: a + ~b + 1). Carry out is discarded.
// Ports   : a_i, b_i  in  W  operands
//           resta_i   in  1  select subtraction
//           s_o       out W  result
// Revision: 1.0 - initial release
// ============================================================================
module sum_resta_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         resta_i,
    output logic [W-1:0] s_o
);

    logic [W-1:0] w_b;
    logic [W-1:0] w_cin;

    assign w_b   = b_i ^ {W{resta_i}};
    assign w_cin = {{(W-1){1'b0}}, resta_i};
    assign s_o   = a_i + w_b + w_cin;

endmodule
`default_nettype wire

// File: rtl/division_restauracion.sv
`default_nettype none
// ============================================================================
// Module  : division_restauracion
// Purpose : Sequential restoring divider, one shift-subtract step per clock.
//           A start in IDLE/HECHO loads the operands; N OPERA cycles and one
//           AJUSTE cycle later the registered quotient/remainder are valid
//           with fin=1. Divide by zero runs the same latency and flags error.
// Config  : DIVISION_SIGNED_EN - two's complement operands (quotient truncates
//           toward zero, remainder follows the dividend sign, most-negative
//           divided by -1 flags error). Undefined: unsigned operands.
// Ports   : clk, reset (sync, active high), start
//           dividendo, divisor   in  N
//           cociente, resto      out N  registered results
//           fin                  out 1  results valid (level)
//           ocupado              out 1  high in OPERA and AJUSTE
//           error                out 1  divide by zero / signed overflow
// Notes   : N >= 2.
// Revision: 1.0 - initial release
// ============================================================================
module division_restauracion
    import division_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] resto,
    output logic         fin,
    output logic         ocupado,
    output logic         error
);

    localparam int CW = cnt_width(N);

    estado_t       estado_q, estado_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic          sgn_dvd_q, sgn_dvd_d;
    logic          sgn_dvs_q, sgn_dvs_d;
    logic          cero_q, cero_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  coc_q, coc_d;
    logic [N-1:0]  res_q, res_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;

    // ------------------------------------------------------------------
    // Operand conditioning at load time
    // ------------------------------------------------------------------
    logic          w_sgn_dvd, w_sgn_dvs, w_ovf;
    logic [N-1:0]  w_mag_dvd, w_mag_dvs;

`ifdef DIVISION_SIGNED_EN
    assign w_sgn_dvd = dividendo[N-1];
    assign w_sgn_dvs = divisor[N-1];
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign w_mag_dvd = w_sgn_dvd ? (~dividendo + {{(N-1){1'b0}}, 1'b1}) : dividendo;
    assign w_mag_dvs = w_sgn_dvs ? (~divisor   + {{(N-1){1'b0}}, 1'b1}) : divisor;
    assign w_ovf     = (dividendo == {1'b1, {(N-1){1'b0}}}) && (divisor == {N{1'b1}});
`else
    assign w_sgn_dvd = 1'b0;
    assign w_sgn_dvs = 1'b0;
    assign w_mag_dvd = dividendo;
    assign w_mag_dvs = divisor;
    assign w_ovf     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Trial subtraction on the shifted partial remainder
    // ------------------------------------------------------------------
    logic [N:0] w_a_sh;
    logic [N:0] w_dif;

    assign w_a_sh = {a_q[N-1:0], q_q[N-1]};

    sum_resta_n #(
        .W (N + 1)
    ) u_resta (
        .a_i     (w_a_sh),
        .b_i     (m_q),
        .resta_i (1'b1),
        .s_o     (w_dif)
    );

    // The partial remainder is always below the divisor, so the top bit of A
    // is zero at every shift; it only exists to hold the trial sign.
    logic w_unused;
    assign w_unused = a_q[N];

    // ------------------------------------------------------------------
    // Sign correction applied in AJUSTE
    // ------------------------------------------------------------------
    logic [N-1:0] w_q_fix, w_r_fix;

    assign w_q_fix = (sgn_dvd_q ^ sgn_dvs_q) ? (~q_q + {{(N-1){1'b0}}, 1'b1}) : q_q;
    assign w_r_fix = sgn_dvd_q ? (~a_q[N-1:0] + {{(N-1){1'b0}}, 1'b1}) : a_q[N-1:0];

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dvs_d = sgn_dvs_q;
        cero_d    = cero_q;
        ovf_d     = ovf_q;
        coc_d     = coc_q;
        res_d     = res_q;
        fin_d     = fin_q;
        err_d     = err_q;

        case (estado_q)
            IDLE, HECHO: begin
                if (start) begin
                    estado_d  = OPERA;
                    a_d       = '0;
                    q_d       = w_mag_dvd;
                    m_d       = {1'b0, w_mag_dvs};
                    cnt_d     = CW'(N);
                    dvd_d     = dividendo;
                    sgn_dvd_d = w_sgn_dvd;
                    sgn_dvs_d = w_sgn_dvs;
                    cero_d    = (divisor == '0);
                    ovf_d     = w_ovf;
                    fin_d     = 1'b0;
                end
            end
            OPERA: begin
                // Negative trial result means the divisor did not fit:
                // keep the shifted value and shift a 0 into the quotient.
                a_d   = w_dif[N] ? w_a_sh : w_dif;
                q_d   = {q_q[N-2:0], ~w_dif[N]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    estado_d = AJUSTE;
                end
            end
            AJUSTE: begin
                if (cero_q) begin
                    coc_d = '1;
                    res_d = dvd_q;
                    err_d = 1'b1;
                end else if (ovf_q) begin
                    coc_d = {1'b1, {(N-1){1'b0}}};
                    res_d = '0;
                    err_d = 1'b1;
                end else begin
                    coc_d = w_q_fix;
                    res_d = w_r_fix;
                    err_d = 1'b0;
                end
                fin_d    = 1'b1;
                estado_d = HECHO;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            cero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            coc_q     <= '0;
            res_q     <= '0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dvs_q <= sgn_dvs_d;
            cero_q    <= cero_d;
            ovf_q     <= ovf_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
        end
    end

    assign cociente = coc_q;
    assign resto    = res_q;
    assign fin      = fin_q;
    assign error    = err_q;
    assign ocupado  = (estado_q == OPERA) || (estado_q == AJUSTE);

endmodule
`default_nettype wire

// File: tb/tb_division_restauracion.sv
`default_nettype none
// ============================================================================
// Module  : tb_division_restauracion
// Purpose : Self-checking bench for division_restauracion (N=3). Expected
//           results come from a vector table and from an integer-arithmetic
//           reference model; they are queued when a division is launched and
//           popped when fin rises.
// Revision: 1.0 - initial release
// ============================================================================
module tb_division_restauracion;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic [N-1:0] cociente;
    logic [N-1:0] resto;
    logic         fin;
    logic         ocupado;
    logic         error;

    division_restauracion #(
        .N (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .resto     (resto),
        .fin       (fin),
        .ocupado   (ocupado),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         e;
    } exp_t;

    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: integer division (SV truncates toward zero, remainder keeps
    // the dividend sign), plus the divide-by-zero and overflow rules.
    function automatic exp_t model(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        int   sd, ss, qi, ri;
        e.q = '0; e.r = '0; e.e = 1'b0;
        sd = 0; ss = 0; qi = 0; ri = 0;
        if (dvs == '0) begin
            e.q = '1; e.r = dvd; e.e = 1'b1;
        end else begin
`ifdef DIVISION_SIGNED_EN
            sd = $signed(dvd);
            ss = $signed(dvs);
            if (sd == -(2 ** (N - 1)) && ss == -1) begin
                e.q = {1'b1, {(N-1){1'b0}}}; e.r = '0; e.e = 1'b1;
            end else begin
                qi = sd / ss;
                ri = sd % ss;
                e.q = qi[N-1:0];
                e.r = ri[N-1:0];
            end
`else
            sd = int'(dvd);
            ss = int'(dvs);
            qi = sd / ss;
            ri = sd % ss;
            e.q = qi[N-1:0];
            e.r = ri[N-1:0];
`endif
        end
        return e;
    endfunction

    // Drive a start for one accepting edge; returns #1 after that edge.
    task automatic launch(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                          input exp_t e, input bit push, input bit hold);
        @(negedge clk);
        start     = 1'b1;
        dividendo = dvd;
        divisor   = dvs;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called #1 after some edge of a running division; edges0/busy0 are the
    // edges already elapsed since acceptance and busy cycles already seen.
    task automatic wait_result(input string tag, input int edges0, input int busy0);
        int   edges;
        int   busy;
        exp_t e;
        edges = edges0;
        busy  = busy0;
        while (!fin && edges < 20) begin
            if (ocupado) busy++;
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, " latency"}, edges, N + 1);
        chk({tag, " busy"}, busy, N + 1);
        chk({tag, " ocupado_at_fin"}, ocupado, 0);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, " cociente"}, cociente, e.q);
            chk({tag, " resto"}, resto, e.r);
            chk({tag, " error"}, error, e.e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " cociente"}, cociente, 0);
        chk({tag, " resto"}, resto, 0);
        chk({tag, " fin"}, fin, 0);
        chk({tag, " ocupado"}, ocupado, 0);
        chk({tag, " error"}, error, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;

`ifdef DIVISION_SIGNED_EN
        tbl.push_back('{3'b101, 3'b010, 3'b111, 3'b111, 1'b0}); // -3 / 2
        tbl.push_back('{3'b100, 3'b111, 3'b100, 3'b000, 1'b1}); // -4 / -1
        tbl.push_back('{3'b011, 3'b110, 3'b111, 3'b001, 1'b0}); //  3 / -2
        tbl.push_back('{3'b100, 3'b011, 3'b111, 3'b111, 1'b0}); // -4 / 3
        tbl.push_back('{3'b010, 3'b000, 3'b111, 3'b010, 1'b1}); //  2 / 0
        tbl.push_back('{3'b011, 3'b001, 3'b011, 3'b000, 1'b0}); //  3 / 1
        tbl.push_back('{3'b110, 3'b110, 3'b001, 3'b000, 1'b0}); // -2 / -2
`else
        tbl.push_back('{3'd7, 3'd2, 3'd3, 3'd1, 1'b0});
        tbl.push_back('{3'd5, 3'd0, 3'd7, 3'd5, 1'b1});
        tbl.push_back('{3'd6, 3'd3, 3'd2, 3'd0, 1'b0});
        tbl.push_back('{3'd4, 3'd3, 3'd1, 3'd1, 1'b0});
        tbl.push_back('{3'd7, 3'd7, 3'd1, 3'd0, 1'b0});
        tbl.push_back('{3'd3, 3'd2, 3'd1, 3'd1, 1'b0});
        tbl.push_back('{3'd0, 3'd5, 3'd0, 3'd0, 1'b0});
        tbl.push_back('{3'd1, 3'd7, 3'd0, 3'd1, 1'b0});
        tbl.push_back('{3'd6, 3'd4, 3'd1, 3'd2, 1'b0});
        tbl.push_back('{3'd7, 3'd1, 3'd7, 3'd0, 1'b0});
`endif

        reset     = 1'b1;
        start     = 1'b0;
        dividendo = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("reset");

        // Table vectors, with a check that results hold in HECHO
        foreach (tbl[i]) begin
            v = tbl[i];
            e.q = v.q; e.r = v.r; e.e = v.e;
            launch(v.dvd, v.dvs, e, 1'b1, 1'b0);
            wait_result($sformatf("tbl%0d", i), 0, 0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d hold_fin", i), fin, 1);
            chk($sformatf("tbl%0d hold_cociente", i), cociente, v.q);
        end

        // All operand pairs against the reference model
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                e = model(a[N-1:0], b[N-1:0]);
                launch(a[N-1:0], b[N-1:0], e, 1'b1, 1'b0);
                wait_result($sformatf("all %0d/%0d", a, b), 0, 0);
            end
        end

        // start during OPERA is ignored
        e = model(3'd6, 3'd3);
        launch(3'd6, 3'd3, e, 1'b1, 1'b0);
        chk("ign ocupado", ocupado, 1);
        @(negedge clk);
        start     = 1'b1;
        dividendo = 3'd1;
        divisor   = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("ign", 1, 1);

        // reset in the second OPERA cycle
        e = model(3'd7, 3'd2);
        launch(3'd7, 3'd2, e, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("midrst");
        e = model(3'd4, 3'd3);
        launch(3'd4, 3'd3, e, 1'b1, 1'b0);
        wait_result("after_rst", 0, 0);

        // back-to-back with start held high
        e = model(3'd7, 3'd7);
        launch(3'd7, 3'd7, e, 1'b1, 1'b1);
        dividendo = 3'd3;
        divisor   = 3'd2;
        sb.push_back(model(3'd3, 3'd2));
        wait_result("b2b_1", 0, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b fin_one_cycle", fin, 0);
        wait_result("b2b_2", 0, 0);

        chk("sb drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
